line_chain_engine: RTL and testbench

Parametrised successor to the single-shot line drawer. It accepts a queue of endpoints and draws connected polylines with Bresenham's algorithm at one pixel per clock. The current origin is taken from the previous endpoint, or set by a move command. Sits between the user/CPU command source and vga_adapter; drives vga_adapter x/y/colour/plot directly.

---
 rtl/line_chain_engine.sv | 272 +++++++++++++++++++++++++++
 tb/tb_line_chain_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/line_chain_engine.sv
// Queued polyline engine: buffers endpoint commands and draws connected
// Bresenham lines at one pixel per clock straight into vga_adapter.
module line_chain_engine #(
  parameter int X_WIDTH      = 9,
  parameter int Y_WIDTH      = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int X_MAX        = 319,
  parameter int Y_MAX        = 239,
  parameter int FIFO_DEPTH   = 4,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [X_WIDTH-1:0]      cmd_x,
  input  logic [Y_WIDTH-1:0]      cmd_y,
  input  logic [COLOUR_WIDTH-1:0] cmd_colour,
  input  logic                    cmd_move,
  output logic [X_WIDTH-1:0]      vga_x,
  output logic [Y_WIDTH-1:0]      vga_y,
  output logic [COLOUR_WIDTH-1:0] vga_colour,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = X_WIDTH + Y_WIDTH + COLOUR_WIDTH + 1;
  localparam int CW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

  localparam logic [X_WIDTH-1:0] X_LIM    = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] Y_LIM    = Y_WIDTH'(Y_MAX);
  localparam logic [X_WIDTH-1:0] ORIG_X_V = X_WIDTH'(ORIGIN_X);
  localparam logic [Y_WIDTH-1:0] ORIG_Y_V = Y_WIDTH'(ORIGIN_Y);
  localparam logic [AW:0]        FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_DRAW   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    push_s, pop_s;

  logic [1:0]              state_q, state_d;
  logic [EW-1:0]           ent_q, ent_d;
  logic [X_WIDTH-1:0]      origin_x_q, origin_x_d;
  logic [Y_WIDTH-1:0]      origin_y_q, origin_y_d;
  logic [X_WIDTH-1:0]      cur_x_q, cur_x_d;
  logic [Y_WIDTH-1:0]      cur_y_q, cur_y_d;
  logic [X_WIDTH-1:0]      end_x_q, end_x_d;
  logic [Y_WIDTH-1:0]      end_y_q, end_y_d;
  logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
  logic signed [CW-1:0]    dx_q, dx_d;
  logic signed [CW-1:0]    dy_q, dy_d;
  logic signed [CW-1:0]    err_q, err_d;
  logic                    sx_neg_q, sx_neg_d;
  logic                    sy_neg_q, sy_neg_d;

  logic [X_WIDTH-1:0]      vga_x_q, vga_x_d;
  logic [Y_WIDTH-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_WIDTH-1:0] vga_colour_q, vga_colour_d;
  logic                    vga_plot_q, vga_plot_d;
  logic                    done_q, done_d;

  logic [X_WIDTH-1:0]      ent_x_s;
  logic [Y_WIDTH-1:0]      ent_y_s;
  logic [COLOUR_WIDTH-1:0] ent_colour_s;
  logic                    ent_move_s;
  logic signed [CW-1:0]    diff_x_s, diff_y_s;
  logic signed [CW:0]      e2_s, dx_ext_s, dy_ext_s;
  logic                    step_x_s, step_y_s;

  assign ent_x_s      = ent_q[EW-1 -: X_WIDTH];
  assign ent_y_s      = ent_q[EW-1-X_WIDTH -: Y_WIDTH];
  assign ent_colour_s = ent_q[COLOUR_WIDTH:1];
  assign ent_move_s   = ent_q[0];

  // No bypass: ready depends only on the registered fill level.
  assign cmd_ready = (count_q != FULL_CNT);
  assign push_s    = cmd_valid && cmd_ready;
  assign pop_s     = (state_q == S_IDLE) && (count_q != {(AW + 1){1'b0}});
  assign busy      = (state_q != S_IDLE) || (count_q != {(AW + 1){1'b0}});

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign done       = done_q;

  // Line setup differences and per-pixel error terms (2*err kept one bit wider).
  always_comb begin
    diff_x_s = $signed(CW'(ent_x_s)) - $signed(CW'(origin_x_q));
    diff_y_s = $signed(CW'(ent_y_s)) - $signed(CW'(origin_y_q));
    e2_s     = $signed({err_q, 1'b0});
    dx_ext_s = $signed({dx_q[CW-1], dx_q});
    dy_ext_s = $signed({dy_q[CW-1], dy_q});
    step_x_s = (e2_s >= dy_ext_s);
    step_y_s = (e2_s <= dx_ext_s);
  end

  // Queue pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Engine state machine: pop, set up, step pixels, retire.
  always_comb begin
    state_d      = state_q;
    ent_d        = ent_q;
    origin_x_d   = origin_x_q;
    origin_y_d   = origin_y_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    end_x_d      = end_x_q;
    end_y_d      = end_y_q;
    colour_d     = colour_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    err_d        = err_q;
    sx_neg_d     = sx_neg_q;
    sy_neg_d     = sy_neg_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          ent_d   = mem_q[rd_ptr_q];
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (ent_move_s) begin
          origin_x_d = ent_x_s;
          origin_y_d = ent_y_s;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cur_x_d  = origin_x_q;
          cur_y_d  = origin_y_q;
          end_x_d  = ent_x_s;
          end_y_d  = ent_y_s;
          colour_d = ent_colour_s;
          sx_neg_d = diff_x_s < $signed({CW{1'b0}});
          sy_neg_d = diff_y_s < $signed({CW{1'b0}});
          dx_d     = sx_neg_d ? -diff_x_s : diff_x_s;
          dy_d     = sy_neg_d ? diff_y_s : -diff_y_s;
          err_d    = dx_d + dy_d;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        vga_x_d      = cur_x_q;
        vga_y_d      = cur_y_q;
        vga_colour_d = colour_q;
        vga_plot_d   = (cur_x_q <= X_LIM) && (cur_y_q <= Y_LIM);
        if ((cur_x_q == end_x_q) && (cur_y_q == end_y_q)) begin
          state_d = S_FINISH;
        end else begin
          err_d = err_q + (step_x_s ? dy_q : {CW{1'b0}})
                        + (step_y_s ? dx_q : {CW{1'b0}});
          if (step_x_s) begin
            cur_x_d = sx_neg_q ? (cur_x_q - X_WIDTH'(1)) : (cur_x_q + X_WIDTH'(1));
          end else begin
            cur_x_d = cur_x_q;
          end
          if (step_y_s) begin
            cur_y_d = sy_neg_q ? (cur_y_q - Y_WIDTH'(1)) : (cur_y_q + Y_WIDTH'(1));
          end else begin
            cur_y_d = cur_y_q;
          end
          state_d = S_DRAW;
        end
      end
      S_FINISH: begin
        origin_x_d = end_x_q;
        origin_y_d = end_y_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Queue storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_x, cmd_y, cmd_colour, cmd_move};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {(AW + 1){1'b0}};
      state_q      <= S_IDLE;
      ent_q        <= {EW{1'b0}};
      origin_x_q   <= ORIG_X_V;
      origin_y_q   <= ORIG_Y_V;
      cur_x_q      <= {X_WIDTH{1'b0}};
      cur_y_q      <= {Y_WIDTH{1'b0}};
      end_x_q      <= {X_WIDTH{1'b0}};
      end_y_q      <= {Y_WIDTH{1'b0}};
      colour_q     <= {COLOUR_WIDTH{1'b0}};
      dx_q         <= {CW{1'b0}};
      dy_q         <= {CW{1'b0}};
      err_q        <= {CW{1'b0}};
      sx_neg_q     <= 1'b0;
      sy_neg_q     <= 1'b0;
      vga_x_q      <= {X_WIDTH{1'b0}};
      vga_y_q      <= {Y_WIDTH{1'b0}};
      vga_colour_q <= {COLOUR_WIDTH{1'b0}};
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      ent_q        <= ent_d;
      origin_x_q   <= origin_x_d;
      origin_y_q   <= origin_y_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      end_x_q      <= end_x_d;
      end_y_q      <= end_y_d;
      colour_q     <= colour_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      err_q        <= err_d;
      sx_neg_q     <= sx_neg_d;
      sy_neg_q     <= sy_neg_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_line_chain_engine.sv
// Directed bench for line_chain_engine: a reference Bresenham model fills a
// pixel scoreboard at push time; a monitor pops and compares every plot.
module tb_line_chain_engine;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_x;
  logic [7:0] cmd_y;
  logic [2:0] cmd_colour;
  logic       cmd_move;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int exp_done = 0;
  int ox = 0;
  int oy = 0;
  logic [19:0] exp_q[$];

  line_chain_engine dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_colour(cmd_colour), .cmd_move(cmd_move),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue every visible pixel of the command, update origin.
  task automatic model_cmd(input int x, input int y, input int c, input bit mv);
    int x0, y0, dx, dy, sx, sy, err, e2;
    if (!mv) begin
      x0 = ox; y0 = oy;
      dx = (x >= x0) ? x - x0 : x0 - x;
      dy = (y >= y0) ? y0 - y : y - y0;
      sx = (x >= x0) ? 1 : -1;
      sy = (y >= y0) ? 1 : -1;
      err = dx + dy;
      for (int k = 0; k < 2000; k++) begin
        if (x0 <= 319 && y0 <= 239) exp_q.push_back({9'(x0), 8'(y0), 3'(c)});
        if (x0 == x && y0 == y) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x0 += sx; end
        if (e2 <= dx) begin err += dx; y0 += sy; end
      end
    end
    ox = x; oy = y;
    exp_done++;
  endtask

  task automatic push(input int x, input int y, input int c, input bit mv);
    int guard = 0;
    @(negedge clock);
    while (!cmd_ready && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    if (!cmd_ready) check("push_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_colour = 3'(c); cmd_move = mv;
    model_cmd(x, y, c, mv);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    @(negedge clock);
    while (busy && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    repeat (2) @(negedge clock);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pixels_left"}, exp_q.size(), 32'd0);
    check({tag, "_done_count"}, done_seen, exp_done);
  endtask

  // Scoreboard monitor: every plotted pixel must be the next expected one.
  always @(negedge clock) begin
    logic [19:0] e;
    if (resetn && vga_plot) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 20'bx;
      check("pixel", {12'd0, vga_x, vga_y, vga_colour}, {12'd0, e});
    end
    if (resetn && done) done_seen++;
  end

  initial begin
    int lat;
    int np;
    int guard;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_x = 9'd0; cmd_y = 8'd0;
    cmd_colour = 3'd0; cmd_move = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_plot", {31'd0, vga_plot}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_xyc", {12'd0, vga_x, vga_y, vga_colour}, 32'd0);
    resetn = 1'b1;

    // Horizontal line from reset origin, with latency and pixel-run checks.
    push(3, 0, 7, 1'b0);
    lat = 0;
    while (!vga_plot && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("first_plot_latency", lat, 32'd4);
    np = 0; guard = 0;
    while (!done && guard < 20) begin
      if (vga_plot) np++;
      @(negedge clock);
      guard++;
    end
    check("pixel_run_len", np, 32'd4);
    wait_idle("t1");

    // Move then diagonal-ish draw.
    push(10, 10, 2, 1'b1);
    push(13, 12, 5, 1'b0);
    wait_idle("t2");

    // Single-pixel line (endpoint equals origin).
    push(0, 0, 3, 1'b1);
    push(0, 0, 6, 1'b0);
    wait_idle("t3");

    // Queue fills while a long line draws; sixth command must wait.
    push(200, 0, 1, 1'b0);
    push(200, 3, 2, 1'b0);
    push(190, 3, 3, 1'b0);
    push(190, 0, 4, 1'b0);
    push(5, 1, 5, 1'b0);
    @(negedge clock);
    check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    push(0, 0, 6, 1'b0);
    wait_idle("t4");

    // Off-screen traversal; then draw back to prove origin moved to x=325.
    push(315, 0, 7, 1'b1);
    push(325, 0, 4, 1'b0);
    wait_idle("t5a");
    push(319, 0, 2, 1'b0);
    wait_idle("t5b");

    // Reset in the middle of a long diagonal.
    push(0, 0, 1, 1'b1);
    push(100, 100, 5, 1'b0);
    repeat (30) @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    exp_q.delete();
    exp_done--;
    ox = 0; oy = 0;
    @(negedge clock);
    check("midrst_plot", {31'd0, vga_plot}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    resetn = 1'b1;
    push(2, 1, 3, 1'b0);
    wait_idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
